if_fetch_unit: RTL and testbench

// - IF-stage producer for the IF/ID pipeline register; drives if_pc4/if_inst into it.
// - Owns the PC and fetches from a variable-latency instruction memory (req/ack).
// - Applies ID-stage redirects using delayed-branch semantics: the instruction in IF is the delay slot.
// - Makes stalls work, because the IF/ID register loads on every clk edge: during stall this block re-presents the last delivered pair.

---
 rtl/if_fetch_unit_pkg.sv | 33 +++
 rtl/if_fetch_unit_if.sv | 18 +
 rtl/if_fetch_unit_pc_next_sel.sv | 42 ++++
 rtl/if_fetch_unit.sv | 139 +++++++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg
// Shared types and constants for the IF-stage fetch unit:
//   state_t      FETCH/HOLD encodings of the fetch FSM
//   PCSRC_*      ID-stage redirect select encodings
//   NOP_INST_DEF bubble word (sll $0,$0,0)
//   fetch_dbg_t  debug view of the fetch unit's internal state
//   word_align() clears the byte-offset bits of an address
package if_fetch_unit_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BPC = 2'b01;
   localparam logic [1:0] PCSRC_RPC = 2'b10;
   localparam logic [1:0] PCSRC_JPC = 2'b11;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      state_t      state;
      logic [31:0] pc;
      logic        redir_pend;
   } fetch_dbg_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if
// Instruction-memory fetch bus.
//   req    fetch request, held with addr until ack
//   addr   word-aligned fetch address
//   ack    rdata valid this cycle; may assert in the same cycle as req
//   rdata  instruction word
// Handshake: a transfer completes on a rising edge where req=1 and ack=1.
// req/addr stay stable from the first cycle req is raised until that edge;
// the requester may abandon a request only through reset.
interface if_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit_pc_next_sel.sv
// if_fetch_unit_pc_next_sel
// Combinational next-PC selection.
//   pc          current fetch PC
//   pcsrc       ID redirect select (PCSRC_*)
//   bpc/rpc/jpc branch / jr / jump targets
//   redir_pend  a redirect was captured earlier and is still owed
//   redir_pc    the captured redirect target
//   tgt         target selected by pcsrc (word aligned)
//   nxt         PC to load when the current instruction is consumed
module if_fetch_unit_pc_next_sel
   import if_fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pcsrc,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   input  logic        redir_pend,
   input  logic [31:0] redir_pc,
   output logic [31:0] tgt,
   output logic [31:0] nxt
);

   always_comb begin
      tgt = 32'h0;
      case (pcsrc)
         PCSRC_BPC: tgt = word_align(bpc);
         PCSRC_RPC: tgt = word_align(rpc);
         PCSRC_JPC: tgt = word_align(jpc);
         default:   tgt = 32'h0;
      endcase

      // A live redirect from ID is newer than anything captured earlier.
      if (pcsrc != PCSRC_SEQ)
         nxt = tgt;
      else if (redir_pend)
         nxt = redir_pc;
      else
         nxt = pc + 32'd4;   // wraps FFFF_FFFC -> 0 naturally
   end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// IF-stage producer for the IF/ID pipeline register. Owns the PC, fetches
// from a variable-latency instruction memory and applies ID redirects with
// delayed-branch semantics (the instruction currently in IF is the delay
// slot). Because IF/ID loads on every edge, a stall is honoured by
// re-presenting the last delivered pc4/inst pair.
// Ports:
//   clk, clrn   clock (rising edge), asynchronous active-low reset
//   stall       ID must hold its current instruction
//   pcsrc       redirect select: 00 seq, 01 bpc, 10 rpc, 11 jpc
//   bpc/rpc/jpc redirect targets
//   imem        instruction-memory bus (master side)
//   if_pc4      PC+4 of the presented instruction
//   if_inst     presented instruction
//   if_valid    1 = if_inst is a real fetched instruction
//   dbg         internal state view (FSM state, pc, redir_pend)
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
)(
   input  logic                   clk,
   input  logic                   clrn,
   input  logic                   stall,
   input  logic [1:0]             pcsrc,
   input  logic [31:0]            bpc,
   input  logic [31:0]            rpc,
   input  logic [31:0]            jpc,
   if_fetch_unit_if.master        imem,
   output logic [31:0]            if_pc4,
   output logic [31:0]            if_inst,
   output logic                   if_valid,
   output fetch_dbg_t             dbg
);

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] buf_inst;
   logic [31:0] last_pc4;
   logic [31:0] last_inst;
   logic        redir_pend;
   logic [31:0] redir_pc;

   logic [31:0] pc4;
   logic [31:0] tgt;
   logic [31:0] nxt;
   logic        fetch_ack;
   logic        consume;
   logic        park;

   assign pc4 = pc + 32'd4;

   if_fetch_unit_pc_next_sel u_pc_next_sel (
      .pc         (pc),
      .pcsrc      (pcsrc),
      .bpc        (bpc),
      .rpc        (rpc),
      .jpc        (jpc),
      .redir_pend (redir_pend),
      .redir_pc   (redir_pc),
      .tgt        (tgt),
      .nxt        (nxt)
   );

   // Gating with clrn makes req fall as soon as reset asserts, not at the
   // next edge; an in-flight request is simply abandoned.
   assign imem.req  = (state == FETCH) && clrn;
   assign imem.addr = pc;

   assign dbg = '{state: state, pc: pc, redir_pend: redir_pend};

   // FSM state register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   // FSM next state and presented pair
   always_comb begin
      state_nxt = state;
      fetch_ack = (state == FETCH) && imem.ack;
      consume   = !stall && ((state == HOLD) || fetch_ack);
      // A word arriving while ID is stalled is parked until the stall ends.
      park      = stall && fetch_ack;
      if_pc4    = pc4;
      if_inst   = NOP_INST;
      if_valid  = 1'b0;

      if (stall) begin
         if_pc4  = last_pc4;
         if_inst = last_inst;
      end else if (state == HOLD) begin
         if_inst  = buf_inst;
         if_valid = 1'b1;
      end else if (fetch_ack) begin
         if_inst  = imem.rdata;
         if_valid = 1'b1;
      end

      if (consume)
         state_nxt = FETCH;
      else if (park)
         state_nxt = HOLD;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pc         <= RESET_PC;
         buf_inst   <= NOP_INST;
         last_pc4   <= 32'h0;
         last_inst  <= NOP_INST;
         redir_pend <= 1'b0;
         redir_pc   <= 32'h0;
      end else begin
         // Bubbles are recorded too, so a stall after a bubble repeats it.
         if (!stall) begin
            last_pc4  <= if_pc4;
            last_inst <= if_inst;
         end

         if (park)
            buf_inst <= imem.rdata;

         if (consume) begin
            pc         <= nxt;
            redir_pend <= 1'b0;
         end else if (!stall && (pcsrc != PCSRC_SEQ)) begin
            // Delay slot not delivered yet: remember where to go after it.
            redir_pend <= 1'b1;
            redir_pc   <= tgt;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  pcsrc = 2'b00;
   logic [31:0] bpc = 32'h0;
   logic [31:0] rpc = 32'h0;
   logic [31:0] jpc = 32'h0;
   logic [31:0] if_pc4;
   logic [31:0] if_inst;
   logic        if_valid;
   fetch_dbg_t  dbg;

   int errors = 0;
   int checks = 0;
   int unsigned mem_wait = 0;
   logic [3:0]  mem_cnt;

   if_fetch_unit_if imem_bus ();

   if_fetch_unit dut (
      .clk      (clk),
      .clrn     (clrn),
      .stall    (stall),
      .pcsrc    (pcsrc),
      .bpc      (bpc),
      .rpc      (rpc),
      .jpc      (jpc),
      .imem     (imem_bus),
      .if_pc4   (if_pc4),
      .if_inst  (if_inst),
      .if_valid (if_valid),
      .dbg      (dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   // instruction memory model: mem_wait idle cycles, then ack
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   assign imem_bus.ack   = imem_bus.req && (mem_cnt == mem_wait[3:0]);
   assign imem_bus.rdata = imem_bus.ack ? mem_word(imem_bus.addr) : 32'hDEAD_BEEF;

   always @(posedge clk or negedge clrn) begin
      if (!clrn)
         mem_cnt <= 4'd0;
      else if (!imem_bus.req || imem_bus.ack)
         mem_cnt <= 4'd0;
      else
         mem_cnt <= mem_cnt + 4'd1;
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0; stall = 1'b0; pcsrc = 2'b00;
      bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;   // returns at the start of cycle 0 after reset
   endtask

   task automatic test_reset();
      mem_wait = 0;
      @(negedge clk);
      clrn = 1'b0; stall = 1'b0; pcsrc = 2'b00;
      #1;
      checks++; if (imem_bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_bus.req); end
      checks++; if (dbg.state !== FETCH) begin errors++; $display("FAIL reset_state: got %b want FETCH", dbg.state); end
      checks++; if (dbg.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", dbg.pc); end
      checks++; if (dbg.redir_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", dbg.redir_pend); end
      checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc4 !== 32'h4) begin errors++; $display("FAIL reset_out: got v=%b i=%h p=%h want 0/0/4", if_valid, if_inst, if_pc4); end
      @(negedge clk);
      clrn = 1'b1;
      #1;
      checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_bus.req, imem_bus.addr); end
   endtask

   task automatic test_zero_wait();
      mem_wait = 0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (imem_bus.addr !== 32'(4 * k)) begin errors++; $display("FAIL zw_addr%0d: got %h want %h", k, imem_bus.addr, 32'(4 * k)); end
         checks++; if (if_pc4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL zw_pc4%0d: got %h want %h", k, if_pc4, 32'(4 * k + 4)); end
         checks++; if (if_valid !== 1'b1 || if_inst !== mem_word(32'(4 * k))) begin errors++; $display("FAIL zw_inst%0d: got v=%b %h want 1 %h", k, if_valid, if_inst, mem_word(32'(4 * k))); end
         @(negedge clk);
      end
   endtask

   task automatic test_two_wait();
      mem_wait = 2;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'((c / 3) * 4)) begin errors++; $display("FAIL tw_addr%0d: got req=%b %h want 1 %h", c, imem_bus.req, imem_bus.addr, 32'((c / 3) * 4)); end
         checks++; if (if_valid !== ((c % 3) == 2)) begin errors++; $display("FAIL tw_valid%0d: got %b want %b", c, if_valid, ((c % 3) == 2)); end
         if ((c % 3) != 2) begin
            checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL tw_nop%0d: got %h want 0", c, if_inst); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      mem_wait = 0;
      do_reset();
      repeat (2) @(negedge clk);
      stall = 1'b1;   // cycle 2, fetch of pc=8 acked this cycle
      #1;
      checks++; if (if_inst !== mem_word(32'h4) || if_pc4 !== 32'h8 || if_valid !== 1'b0) begin errors++; $display("FAIL st_repeat0: got %h/%h/%b want %h/8/0", if_inst, if_pc4, if_valid, mem_word(32'h4)); end
      checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h8) begin errors++; $display("FAIL st_req0: got %b/%h want 1/8", imem_bus.req, imem_bus.addr); end
      @(negedge clk);
      #1;
      checks++; if (dbg.state !== HOLD || imem_bus.req !== 1'b0 || dbg.pc !== 32'h8) begin errors++; $display("FAIL st_hold: got st=%b req=%b pc=%h want HOLD/0/8", dbg.state, imem_bus.req, dbg.pc); end
      checks++; if (if_inst !== mem_word(32'h4) || if_valid !== 1'b0) begin errors++; $display("FAIL st_repeat1: got %h/%b want %h/0", if_inst, if_valid, mem_word(32'h4)); end
      @(negedge clk);
      stall = 1'b0;
      #1;
      checks++; if (if_inst !== mem_word(32'h8) || if_pc4 !== 32'hC || if_valid !== 1'b1) begin errors++; $display("FAIL st_buf: got %h/%h/%b want %h/C/1", if_inst, if_pc4, if_valid, mem_word(32'h8)); end
      @(negedge clk);
      #1;
      checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hC || if_pc4 !== 32'h10) begin errors++; $display("FAIL st_resume: got %b/%h/%h want 1/C/10", imem_bus.req, imem_bus.addr, if_pc4); end
   endtask

   task automatic test_branch();
      mem_wait = 0;
      do_reset();
      repeat (4) @(negedge clk);
      pcsrc = 2'b01; bpc = 32'h0000_0043;   // low bits must be dropped
      #1;
      checks++; if (if_inst !== mem_word(32'h10) || if_pc4 !== 32'h14 || if_valid !== 1'b1) begin errors++; $display("FAIL br_slot: got %h/%h/%b want %h/14/1", if_inst, if_pc4, if_valid, mem_word(32'h10)); end
      @(negedge clk);
      pcsrc = 2'b00;
      #1;
      checks++; if (imem_bus.addr !== 32'h40 || if_pc4 !== 32'h44) begin errors++; $display("FAIL br_target: got %h/%h want 40/44", imem_bus.addr, if_pc4); end
   endtask

   task automatic test_redirect_pending();
      mem_wait = 0;
      do_reset();
      repeat (8) @(negedge clk);
      mem_wait = 3;
      pcsrc = 2'b11; jpc = 32'h0000_0100;
      #1;
      checks++; if (imem_bus.addr !== 32'h20 || if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL rp_wait: got %h/%b/%h want 20/0/0", imem_bus.addr, if_valid, if_inst); end
      @(negedge clk);
      pcsrc = 2'b00;
      #1;
      checks++; if (dbg.redir_pend !== 1'b1 || imem_bus.addr !== 32'h20) begin errors++; $display("FAIL rp_set: got pend=%b addr=%h want 1/20", dbg.redir_pend, imem_bus.addr); end
      @(negedge clk);
      #1;
      checks++; if (imem_bus.addr !== 32'h20 || if_valid !== 1'b0) begin errors++; $display("FAIL rp_stable: got %h/%b want 20/0", imem_bus.addr, if_valid); end
      @(negedge clk);
      #1;
      checks++; if (if_inst !== mem_word(32'h20) || if_pc4 !== 32'h24 || if_valid !== 1'b1) begin errors++; $display("FAIL rp_slot: got %h/%h/%b want %h/24/1", if_inst, if_pc4, if_valid, mem_word(32'h20)); end
      @(negedge clk);
      #1;
      checks++; if (imem_bus.addr !== 32'h100 || dbg.redir_pend !== 1'b0) begin errors++; $display("FAIL rp_target: got %h pend=%b want 100/0", imem_bus.addr, dbg.redir_pend); end
   endtask

   task automatic test_stall_redirect();
      mem_wait = 0;
      do_reset();
      @(negedge clk);
      stall = 1'b1; pcsrc = 2'b10; rpc = 32'h0000_0080;
      @(negedge clk);
      #1;
      checks++; if (dbg.pc !== 32'h4 || dbg.redir_pend !== 1'b0 || dbg.state !== HOLD) begin errors++; $display("FAIL sr_ignore: got pc=%h pend=%b st=%b want 4/0/HOLD", dbg.pc, dbg.redir_pend, dbg.state); end
      @(negedge clk);
      stall = 1'b0; pcsrc = 2'b00;
      #1;
      checks++; if (if_inst !== mem_word(32'h4) || if_pc4 !== 32'h8 || if_valid !== 1'b1) begin errors++; $display("FAIL sr_buf: got %h/%h/%b want %h/8/1", if_inst, if_pc4, if_valid, mem_word(32'h4)); end
      @(negedge clk);
      #1;
      checks++; if (imem_bus.addr !== 32'h8) begin errors++; $display("FAIL sr_seq: got %h want 8", imem_bus.addr); end
   endtask

   task automatic test_wrap();
      mem_wait = 0;
      do_reset();
      pcsrc = 2'b11; jpc = 32'hFFFF_FFFF;
      @(negedge clk);
      pcsrc = 2'b00;
      #1;
      checks++; if (imem_bus.addr !== 32'hFFFF_FFFC || if_pc4 !== 32'h0) begin errors++; $display("FAIL wr_top: got %h/%h want FFFFFFFC/0", imem_bus.addr, if_pc4); end
      @(negedge clk);
      #1;
      checks++; if (imem_bus.addr !== 32'h0) begin errors++; $display("FAIL wr_zero: got %h want 0", imem_bus.addr); end
   endtask

   task automatic test_reset_mid_fetch();
      mem_wait = 3;
      do_reset();
      pcsrc = 2'b11; jpc = 32'h0000_0200;
      @(negedge clk);
      pcsrc = 2'b00;
      #1;
      checks++; if (dbg.redir_pend !== 1'b1 || imem_bus.req !== 1'b1) begin errors++; $display("FAIL rm_pre: got pend=%b req=%b want 1/1", dbg.redir_pend, imem_bus.req); end
      #2;
      clrn = 1'b0; stall = 1'b1;
      #1;
      checks++; if (imem_bus.req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", imem_bus.req); end
      checks++; if (dbg.redir_pend !== 1'b0 || dbg.pc !== 32'h0 || dbg.state !== FETCH) begin errors++; $display("FAIL rm_regs: got pend=%b pc=%h st=%b want 0/0/FETCH", dbg.redir_pend, dbg.pc, dbg.state); end
      checks++; if (if_pc4 !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL rm_last: got %h/%h want 0/0", if_pc4, if_inst); end
      @(negedge clk);
      clrn = 1'b1; stall = 1'b0;
      #1;
      checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin errors++; $display("FAIL rm_restart: got %b/%h want 1/0", imem_bus.req, imem_bus.addr); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_two_wait();
      test_stall();
      test_branch();
      test_redirect_pending();
      test_stall_redirect();
      test_wrap();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
